// File: rtl/pipe_adder_result_buffer_if.sv
// Handshake and data bundle between the adder result buffer and its
// upstream issuer, the adder outputs, and the downstream consumer.
interface pipe_adder_result_buffer_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic             issue;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic [LW-1:0]    level;
  logic             ovf_err;

  // Environment side: issuer, adder outputs and consumer.
  modport master (
    output in_valid, res_sum, res_cout, out_ready,
    input  in_ready, issue, out_valid, out_sum, out_cout, level, ovf_err
  );

  // Buffer side.
  modport slave (
    input  in_valid, res_sum, res_cout, out_ready,
    output in_ready, issue, out_valid, out_sum, out_cout, level, ovf_err
  );
endinterface

// File: rtl/pipe_adder_result_buffer.sv
// Result buffer for a fixed-latency, non-stallable pipelined adder.
// Valid tags ride alongside the adder; results land in a FWFT FIFO.
// Issue is only granted while a FIFO slot can be reserved, so a tagged
// result always finds room when it emerges.
module pipe_adder_result_buffer #(
  parameter int WIDTH   = 64,
  parameter int LATENCY = 4,
  parameter int DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  pipe_adder_result_buffer_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]      level_q, level_d;
  logic [LW-1:0]      rsv_q, rsv_d;
  logic               ovf_q;
  logic [WIDTH:0]     mem_q [DEPTH];

  logic in_rdy, issue, wr, pop, full, wr_en;

  // Credit check uses registered state only; a pop frees its credit next cycle.
  assign in_rdy = (rsv_q < DEPTH_L);
  assign issue  = bus.in_valid & in_rdy;
  assign wr     = vld_pipe_q[LATENCY-1];
  assign pop    = (level_q != '0) & bus.out_ready;
  assign full   = (level_q == DEPTH_L);
  // When full, a write is only safe if the head leaves on the same edge.
  assign wr_en  = wr & (~full | pop);

  assign bus.in_ready  = in_rdy;
  assign bus.issue     = issue;
  assign bus.out_valid = (level_q != '0);
  assign bus.out_sum   = mem_q[rd_ptr_q][WIDTH-1:0];
  assign bus.out_cout  = mem_q[rd_ptr_q][WIDTH];
  assign bus.level     = level_q;
  assign bus.ovf_err   = ovf_q;

  // Tag shift register, no stall: a tag exits exactly when the adder result does.
  always_comb begin
    vld_pipe_d    = '0;
    vld_pipe_d[0] = issue;
    for (int i = 1; i < LATENCY; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
  end

  // Next FIFO occupancy and next credit count.
  always_comb begin
    level_d = level_q;
    case ({wr_en, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    rsv_d = rsv_q;
    case ({issue, pop})
      2'b10:   rsv_d = rsv_q + LW'(1);
      2'b01:   rsv_d = rsv_q - LW'(1);
      default: rsv_d = rsv_q;
    endcase
  end

  // Control state: tags, pointers, counters, sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rsv_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      level_q    <= level_d;
      rsv_q      <= rsv_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PW'(1);
      if (wr & full & ~pop) ovf_q <= 1'b1;
    end
  end

  // FIFO storage; cleared so the idle head reads as zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= {bus.res_cout, bus.res_sum};
    end
  end
endmodule
